carrier_wipeoff_nco: RTL and testbench

Parametrised carrier wipeoff for the acquisition chain. It computes the Doppler frequency word for one bin, runs a phase-accumulator NCO with a sine/cosine LUT, and multiplies each incoming complex baseband sample by e^(-jθ). The result streams out to the correlator. It replaces the fixed-width, CORDIC-based generator with a streaming mixer that has backpressure, per-bin sample counting and abort.

---
 rtl/carrier_wipeoff_nco.sv | 177 +++++++++++++++++
 tb/tb_carrier_wipeoff_nco.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/carrier_wipeoff_nco.sv
// Carrier wipeoff: per-bin Doppler word, phase-accumulator NCO with a sine LUT,
// and a 4-stage complex mixer (x * e^-j*theta) with AXI-Stream backpressure.
module carrier_wipeoff_nco #(
    parameter int DATA_WIDTH     = 32,
    parameter int SAMPLE_WIDTH   = 16,
    parameter int LUT_ADDR_WIDTH = 10,
    parameter int LUT_DATA_WIDTH = 16,
    parameter int OUT_WIDTH      = SAMPLE_WIDTH + LUT_DATA_WIDTH + 1
) (
    input  logic                      axis_aclk,
    input  logic                      axis_aresetn,
    input  logic [DATA_WIDTH-1:0]     doppler_min,
    input  logic [DATA_WIDTH-1:0]     doppler_step,
    input  logic [DATA_WIDTH-1:0]     bin_index,
    input  logic [DATA_WIDTH-1:0]     samples_per_bin,
    input  logic                      start,
    input  logic                      abort,
    input  logic [2*SAMPLE_WIDTH-1:0] s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [2*OUT_WIDTH-1:0]    m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_WIDTH-1:0]     o_sample_count
);
    localparam int LUT_DEPTH = 1 << LUT_ADDR_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic int lut_value(input int k);
        real amp;
        real x;
        amp = real'((1 << (LUT_DATA_WIDTH - 1)) - 1);
        x   = amp * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(LUT_DEPTH));
        if (x >= 0.0) return $rtoi(x + 0.5);
        else          return -$rtoi(0.5 - x);
    endfunction

    logic signed [LUT_DATA_WIDTH-1:0] lut_s [LUT_DEPTH];
    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
        localparam int LV = lut_value(k);
        assign lut_s[k] = LUT_DATA_WIDTH'(LV);
    end

    state_t                    state_r, state_s;
    logic [DATA_WIDTH-1:0]     bin_r, spb_r, fw_r, phase_r, count_r;
    logic                      en_s, accept_s, last_in_s, pipe_empty_s;

    logic                             v1_r, last1_r;
    logic [LUT_ADDR_WIDTH-1:0]        addr_sin1_r, addr_cos1_r;
    logic signed [SAMPLE_WIDTH-1:0]   i1_r, q1_r;
    logic                             v2_r, last2_r;
    logic signed [LUT_DATA_WIDTH-1:0] sin2_r, cos2_r;
    logic signed [SAMPLE_WIDTH-1:0]   i2_r, q2_r;
    logic                             v3_r, last3_r;
    logic signed [OUT_WIDTH-1:0]      i3_r, q3_r;
    logic                             v4_r, last4_r;
    logic signed [OUT_WIDTH-1:0]      i4_r, q4_r;

    // The whole pipeline only freezes while the output register holds an untaken beat.
    assign en_s          = !v4_r || m_axis_tready;
    assign s_axis_tready = (state_r == ST_RUN) && en_s && (count_r < spb_r);
    assign accept_s      = s_axis_tvalid && s_axis_tready;
    assign last_in_s     = (count_r == (spb_r - DATA_WIDTH'(1)));
    assign pipe_empty_s  = !v1_r && !v2_r && !v3_r && (!v4_r || m_axis_tready);

    assign m_axis_tdata   = {q4_r, i4_r};
    assign m_axis_tvalid  = v4_r;
    assign m_axis_tlast   = last4_r;
    assign busy           = (state_r != ST_IDLE);
    assign done           = (state_r == ST_DONE);
    assign o_sample_count = count_r;

    // FSM state register.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) state_r <= ST_IDLE;
        else               state_r <= state_s;
    end

    // FSM next-state logic; abort overrides every transition.
    always_comb begin
        state_s = state_r;
        if (abort) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  if (start) state_s = ST_LOAD; else state_s = ST_IDLE;
                ST_LOAD:  if (spb_r == '0) state_s = ST_DONE; else state_s = ST_RUN;
                ST_RUN:   if (accept_s && last_in_s) state_s = ST_DRAIN; else state_s = ST_RUN;
                ST_DRAIN: if (pipe_empty_s) state_s = ST_DONE; else state_s = ST_DRAIN;
                ST_DONE:  state_s = ST_IDLE;
                default:  state_s = ST_IDLE;
            endcase
        end
    end

    // Bin configuration, frequency word, NCO phase and sample counter.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            bin_r   <= '0;
            spb_r   <= '0;
            fw_r    <= '0;
            phase_r <= '0;
            count_r <= '0;
        end else if (abort) begin
            count_r <= '0;
            phase_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        bin_r   <= bin_index;
                        spb_r   <= samples_per_bin;
                        count_r <= '0;
                        phase_r <= '0;
                    end
                end
                ST_LOAD: fw_r <= doppler_min + doppler_step * bin_r;
                ST_RUN: begin
                    if (accept_s) begin
                        count_r <= count_r + DATA_WIDTH'(1);
                        phase_r <= phase_r + fw_r;
                    end
                end
                default: ;
            endcase
        end
    end

    // Mixer pipeline: addresses, LUT read, complex multiply, output register.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            {v1_r, last1_r, addr_sin1_r, addr_cos1_r, i1_r, q1_r} <= '0;
            {v2_r, last2_r, sin2_r, cos2_r, i2_r, q2_r}           <= '0;
            {v3_r, last3_r, i3_r, q3_r}                           <= '0;
            {v4_r, last4_r, i4_r, q4_r}                           <= '0;
        end else if (abort) begin
            {v1_r, v2_r, v3_r, v4_r}                 <= 4'b0000;
            {last1_r, last2_r, last3_r, last4_r}     <= 4'b0000;
        end else if (en_s) begin
            v1_r        <= accept_s;
            last1_r     <= accept_s && last_in_s;
            addr_sin1_r <= phase_r[DATA_WIDTH-1 -: LUT_ADDR_WIDTH];
            addr_cos1_r <= phase_r[DATA_WIDTH-1 -: LUT_ADDR_WIDTH] + LUT_ADDR_WIDTH'(LUT_DEPTH / 4);
            i1_r        <= s_axis_tdata[SAMPLE_WIDTH-1:0];
            q1_r        <= s_axis_tdata[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH];

            v2_r    <= v1_r;
            last2_r <= last1_r;
            sin2_r  <= lut_s[addr_sin1_r];
            cos2_r  <= lut_s[addr_cos1_r];
            i2_r    <= i1_r;
            q2_r    <= q1_r;

            v3_r    <= v2_r;
            last3_r <= last2_r;
            i3_r    <= OUT_WIDTH'(i2_r) * OUT_WIDTH'(cos2_r) + OUT_WIDTH'(q2_r) * OUT_WIDTH'(sin2_r);
            q3_r    <= OUT_WIDTH'(q2_r) * OUT_WIDTH'(cos2_r) - OUT_WIDTH'(i2_r) * OUT_WIDTH'(sin2_r);

            v4_r    <= v3_r;
            last4_r <= last3_r;
            i4_r    <= i3_r;
            q4_r    <= q3_r;
        end else begin
            v4_r <= v4_r;
        end
    end
endmodule

// File: tb/tb_carrier_wipeoff_nco.sv
// Randomized bench for carrier_wipeoff_nco against a plain-arithmetic mixer model.
module tb_carrier_wipeoff_nco;
    localparam int DW = 32;
    localparam int SW = 16;
    localparam int OW = 33;

    logic            axis_aclk = 1'b0;
    logic            axis_aresetn = 1'b0;
    logic [DW-1:0]   doppler_min = '0, doppler_step = '0, bin_index = '0, samples_per_bin = '0;
    logic            start = 1'b0, abort = 1'b0;
    logic [2*SW-1:0] s_axis_tdata = '0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tready;
    logic [2*OW-1:0] m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b1;
    logic            m_axis_tlast, busy, done;
    logic [DW-1:0]   o_sample_count;

    always #5 axis_aclk = ~axis_aclk;

    carrier_wipeoff_nco dut (
        .axis_aclk(axis_aclk), .axis_aresetn(axis_aresetn),
        .doppler_min(doppler_min), .doppler_step(doppler_step),
        .bin_index(bin_index), .samples_per_bin(samples_per_bin),
        .start(start), .abort(abort),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .busy(busy), .done(done), .o_sample_count(o_sample_count)
    );

    int n_cmp = 0, n_err = 0, cyc = 0;
    always @(posedge axis_aclk) cyc <= cyc + 1;

    logic [31:0] data_mem [256];
    logic [65:0] out_q[$], ref_q[$];
    bit          last_q[$];
    int          out_cyc_q[$], acc_cyc_q[$];
    int          n_acc, done_cnt, done_cyc, start_cyc, stable_err;
    bit          timed_out, aborted, busy_at_done, busy_after, ab_busy, ab_valid;
    logic [31:0] ab_count;

    function automatic int lut_ref(input int k);
        real x;
        x = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 1024.0);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    // Sample n of a bin sees phase n*fw; the top 10 phase bits index the sine table.
    function automatic logic [65:0] model_out(input logic [31:0] fw, input int n, input logic [31:0] d);
        logic [31:0] ph;
        int a, s, c;
        longint iv, qv, ii, qq;
        ph = fw * 32'(n);
        a  = int'(ph >> 22);
        s  = lut_ref(a);
        c  = lut_ref((a + 256) % 1024);
        iv = longint'($signed(d[15:0]));
        qv = longint'($signed(d[31:16]));
        ii = iv * c + qv * s;
        qq = qv * c - iv * s;
        return {qq[32:0], ii[32:0]};
    endfunction

    task automatic tick();
        @(posedge axis_aclk);
        @(negedge axis_aclk);
    endtask

    task automatic run_bin(input logic [31:0] dmin, dstep, bidx, spb, input bit rnd_rdy, rnd_val,
                           input int abort_after, restart_at, budget);
        bit held, restarted;
        logic [65:0] pd;
        logic pl;
        out_q.delete(); last_q.delete(); out_cyc_q.delete(); acc_cyc_q.delete();
        n_acc = 0; done_cnt = 0; done_cyc = -1; stable_err = 0; timed_out = 1'b0; aborted = 1'b0;
        held = 1'b0; restarted = 1'b0; pd = '0; pl = 1'b0;
        doppler_min = dmin; doppler_step = dstep; bin_index = bidx; samples_per_bin = spb;
        start = 1'b1; start_cyc = cyc;
        tick();
        start = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (abort_after >= 0 && n_acc == abort_after) begin
                abort = 1'b1; s_axis_tvalid = 1'b0;
                tick();
                abort = 1'b0;
                ab_busy = busy; ab_valid = m_axis_tvalid; ab_count = o_sample_count;
                for (int j = 0; j < 10; j++) begin
                    if (done) done_cnt++;
                    tick();
                end
                aborted = 1'b1;
                return;
            end
            start = (restart_at >= 0 && n_acc == restart_at && !restarted);
            if (start) begin
                restarted = 1'b1; bin_index = ~bidx; samples_per_bin = spb + 32'd5;
            end
            m_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            s_axis_tvalid = rnd_val ? 1'($urandom_range(0, 1)) : 1'b1;
            s_axis_tdata  = data_mem[n_acc % 256];
            #1;
            if (done) begin
                done_cnt++; done_cyc = cyc; busy_at_done = busy;
            end
            if (held && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd || m_axis_tlast !== pl)) stable_err++;
            held = m_axis_tvalid && !m_axis_tready; pd = m_axis_tdata; pl = m_axis_tlast;
            if (s_axis_tvalid && s_axis_tready) begin
                acc_cyc_q.push_back(cyc); n_acc++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                out_q.push_back(m_axis_tdata); last_q.push_back(m_axis_tlast); out_cyc_q.push_back(cyc);
            end
            tick();
            start = 1'b0;
            if (done_cnt > 0) begin
                busy_after = busy; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
                return;
            end
        end
        timed_out = 1'b1; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL reset_tready got %b want 0", s_axis_tready); end
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
        n_cmp++; if (m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast got %b want 0", m_axis_tlast); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (o_sample_count !== 32'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", o_sample_count); end
        n_cmp++; if (m_axis_tdata !== 66'd0) begin n_err++; $display("FAIL reset_tdata got %h want 0", m_axis_tdata); end
        axis_aresetn = 1'b1;
        tick();
    endtask

    task automatic test_single_bin();
        logic [65:0] exp;
        int ival;
        ival = 1000 * 32767;
        exp = {33'd0, 33'(ival)};
        for (int n = 0; n < 256; n++) data_mem[n] = {16'd0, 16'd1000};
        run_bin(32'd0, 32'd0, 32'd0, 32'd8, 1'b0, 1'b0, -1, -1, 200);
        n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL single_timeout got %b want 0", timed_out); end
        n_cmp++; if (out_q.size() !== 8) begin n_err++; $display("FAIL single_count got %0d want 8", out_q.size()); end
        for (int n = 0; n < out_q.size(); n++) begin
            n_cmp++; if (out_q[n] !== exp) begin n_err++; $display("FAIL single_data[%0d] got %h want %h", n, out_q[n], exp); end
            n_cmp++; if (last_q[n] !== (n == 7)) begin n_err++; $display("FAIL single_last[%0d] got %b want %b", n, last_q[n], n == 7); end
        end
        if (out_cyc_q.size() > 0 && acc_cyc_q.size() == 8) begin
            n_cmp++; if (out_cyc_q[0] - acc_cyc_q[0] !== 4) begin n_err++; $display("FAIL single_latency got %0d want 4", out_cyc_q[0] - acc_cyc_q[0]); end
            n_cmp++; if (acc_cyc_q[7] - acc_cyc_q[0] !== 7) begin n_err++; $display("FAIL single_throughput got %0d want 7", acc_cyc_q[7] - acc_cyc_q[0]); end
            n_cmp++; if (done_cyc - out_cyc_q[$] !== 1) begin n_err++; $display("FAIL single_done_time got %0d want 1", done_cyc - out_cyc_q[$]); end
        end
        n_cmp++; if (busy_at_done !== 1'b1) begin n_err++; $display("FAIL single_busy_at_done got %b want 1", busy_at_done); end
        n_cmp++; if (busy_after !== 1'b0) begin n_err++; $display("FAIL single_busy_after got %b want 0", busy_after); end
        n_cmp++; if (o_sample_count !== 32'd8) begin n_err++; $display("FAIL single_held_count got %0d want 8", o_sample_count); end
    endtask

    task automatic test_bin_arith();
        int ei [4] = '{3276700, 0, -3276700, 0};
        int eq [4] = '{0, -3276700, 0, 3276700};
        logic [65:0] exp;
        for (int n = 0; n < 256; n++) data_mem[n] = {16'd0, 16'd100};
        run_bin(32'h4000_0000, 32'h4000_0000, 32'd0, 32'd4, 1'b0, 1'b0, -1, -1, 200);
        n_cmp++; if (out_q.size() !== 4) begin n_err++; $display("FAIL arith_count got %0d want 4", out_q.size()); end
        for (int n = 0; n < out_q.size() && n < 4; n++) begin
            exp = {33'(eq[n]), 33'(ei[n])};
            n_cmp++; if (out_q[n] !== exp) begin n_err++; $display("FAIL arith_data[%0d] got %h want %h", n, out_q[n], exp); end
        end
    endtask

    task automatic test_wrap();
        for (int n = 0; n < 256; n++) data_mem[n] = $urandom;
        run_bin(32'hFFFF_FFFF, 32'd1, 32'd2, 32'd20, 1'b0, 1'b0, -1, -1, 300);
        n_cmp++; if (out_q.size() !== 20) begin n_err++; $display("FAIL wrap_pos_count got %0d want 20", out_q.size()); end
        for (int n = 0; n < out_q.size(); n++) begin
            n_cmp++; if (out_q[n] !== model_out(32'd1, n, data_mem[n])) begin n_err++; $display("FAIL wrap_pos[%0d] got %h want %h", n, out_q[n], model_out(32'd1, n, data_mem[n])); end
        end
        run_bin(32'hFFFF_FFFF, 32'd1, 32'd0, 32'd6, 1'b0, 1'b0, -1, -1, 300);
        n_cmp++; if (out_q.size() !== 6) begin n_err++; $display("FAIL wrap_neg_count got %0d want 6", out_q.size()); end
        for (int n = 0; n < out_q.size(); n++) begin
            n_cmp++; if (out_q[n] !== model_out(32'hFFFF_FFFF, n, data_mem[n])) begin n_err++; $display("FAIL wrap_neg[%0d] got %h want %h", n, out_q[n], model_out(32'hFFFF_FFFF, n, data_mem[n])); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] dmin, dstep, bidx, fw;
        int nlast;
        dmin = $urandom; dstep = $urandom; bidx = $urandom_range(0, 200);
        fw = dmin + dstep * bidx;
        for (int n = 0; n < 256; n++) data_mem[n] = $urandom;
        run_bin(dmin, dstep, bidx, 32'd64, 1'b0, 1'b0, -1, -1, 400);
        ref_q = out_q;
        run_bin(dmin, dstep, bidx, 32'd64, 1'b1, 1'b1, -1, -1, 2000);
        n_cmp++; if (out_q.size() !== 64) begin n_err++; $display("FAIL bp_count got %0d want 64", out_q.size()); end
        n_cmp++; if (stable_err !== 0) begin n_err++; $display("FAIL bp_stable got %0d unstable stalls want 0", stable_err); end
        nlast = 0;
        for (int n = 0; n < out_q.size(); n++) begin
            if (last_q[n]) nlast++;
            n_cmp++; if (out_q[n] !== model_out(fw, n, data_mem[n])) begin n_err++; $display("FAIL bp_data[%0d] got %h want %h", n, out_q[n], model_out(fw, n, data_mem[n])); end
            if (n < ref_q.size()) begin
                n_cmp++; if (out_q[n] !== ref_q[n]) begin n_err++; $display("FAIL bp_vs_ready_run[%0d] got %h want %h", n, out_q[n], ref_q[n]); end
            end
        end
        n_cmp++; if (nlast !== 1) begin n_err++; $display("FAIL bp_tlast_count got %0d want 1", nlast); end
        if (out_q.size() == 64) begin
            n_cmp++; if (last_q[63] !== 1'b1) begin n_err++; $display("FAIL bp_tlast_pos got %b want 1", last_q[63]); end
        end
    endtask

    task automatic test_abort();
        logic [31:0] dmin, dstep, bidx, fw;
        dmin = $urandom; dstep = $urandom; bidx = $urandom_range(0, 50);
        fw = dmin + dstep * bidx;
        for (int n = 0; n < 256; n++) data_mem[n] = $urandom;
        run_bin(dmin, dstep, bidx, 32'd16, 1'b0, 1'b0, 5, -1, 200);
        n_cmp++; if (aborted !== 1'b1) begin n_err++; $display("FAIL abort_reached got %b want 1", aborted); end
        n_cmp++; if (ab_busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", ab_busy); end
        n_cmp++; if (ab_valid !== 1'b0) begin n_err++; $display("FAIL abort_tvalid got %b want 0", ab_valid); end
        n_cmp++; if (ab_count !== 32'd0) begin n_err++; $display("FAIL abort_count got %0d want 0", ab_count); end
        n_cmp++; if (done_cnt !== 0) begin n_err++; $display("FAIL abort_done_pulses got %0d want 0", done_cnt); end
        run_bin(dmin, dstep, bidx, 32'd16, 1'b0, 1'b0, -1, -1, 300);
        n_cmp++; if (out_q.size() !== 16) begin n_err++; $display("FAIL abort_rerun_count got %0d want 16", out_q.size()); end
        for (int n = 0; n < out_q.size(); n++) begin
            n_cmp++; if (out_q[n] !== model_out(fw, n, data_mem[n])) begin n_err++; $display("FAIL abort_rerun[%0d] got %h want %h", n, out_q[n], model_out(fw, n, data_mem[n])); end
        end
        n_cmp++; if (o_sample_count !== 32'd16) begin n_err++; $display("FAIL abort_rerun_sc got %0d want 16", o_sample_count); end
    endtask

    task automatic test_edge();
        logic [31:0] dmin, dstep, bidx, fw;
        run_bin(32'd7, 32'd3, 32'd1, 32'd0, 1'b0, 1'b0, -1, -1, 50);
        n_cmp++; if (out_q.size() !== 0) begin n_err++; $display("FAIL zero_outputs got %0d want 0", out_q.size()); end
        n_cmp++; if (done_cyc - start_cyc !== 2) begin n_err++; $display("FAIL zero_done_time got %0d want 2", done_cyc - start_cyc); end
        dmin = $urandom; dstep = $urandom; bidx = $urandom_range(0, 50);
        fw = dmin + dstep * bidx;
        for (int n = 0; n < 256; n++) data_mem[n] = $urandom;
        run_bin(dmin, dstep, bidx, 32'd10, 1'b0, 1'b1, -1, 3, 400);
        n_cmp++; if (out_q.size() !== 10) begin n_err++; $display("FAIL restart_count got %0d want 10", out_q.size()); end
        for (int n = 0; n < out_q.size(); n++) begin
            n_cmp++; if (out_q[n] !== model_out(fw, n, data_mem[n])) begin n_err++; $display("FAIL restart_data[%0d] got %h want %h", n, out_q[n], model_out(fw, n, data_mem[n])); end
        end
        n_cmp++; if (o_sample_count !== 32'd10) begin n_err++; $display("FAIL restart_sc got %0d want 10", o_sample_count); end
        doppler_min = dmin; doppler_step = dstep; bin_index = bidx; samples_per_bin = 32'd32;
        start = 1'b1;
        tick();
        start = 1'b0; s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
        repeat (8) tick();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL arst_pre_busy got %b want 1", busy); end
        #2 axis_aresetn = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL arst_busy got %b want 0", busy); end
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL arst_tvalid got %b want 0", m_axis_tvalid); end
        n_cmp++; if (m_axis_tdata !== 66'd0) begin n_err++; $display("FAIL arst_tdata got %h want 0", m_axis_tdata); end
        n_cmp++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL arst_tready got %b want 0", s_axis_tready); end
        n_cmp++; if (o_sample_count !== 32'd0) begin n_err++; $display("FAIL arst_count got %0d want 0", o_sample_count); end
        n_cmp++; if (m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL arst_tlast got %b want 0", m_axis_tlast); end
        @(negedge axis_aclk);
        s_axis_tvalid = 1'b0; axis_aresetn = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_bin();
        test_bin_arith();
        test_wrap();
        test_backpressure();
        test_abort();
        test_edge();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
